// File: rtl/conv_encoder_framer_if.sv
// Bit-in / symbol-out handshake bundle for the convolutional encoder framer.
// The encoder side uses the slave modport, the bit source and symbol sink the master.
interface conv_encoder_framer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=4 convolutional encoder with per-frame zero tail and MAX_FRAME truncation.
//  state | meaning
//  IDLE  | waiting for the first bit of a frame
//  DATA  | accepting data bits, one symbol per bit
//  TAIL  | shifting in three zero tail bits
//  FLUSH | waiting for the final tail symbol to leave, then clear
module conv_encoder_framer #(
  parameter logic [3:0] G0        = 4'b1101,
  parameter logic [3:0] G1        = 4'b1111,
  parameter int         MAX_FRAME = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  conv_encoder_framer_if.slave  bus,
  output logic                  trunc,
  output logic                  busy
);
  localparam int CW = $clog2(MAX_FRAME + 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

  state_t        state, state_nx;
  logic [2:0]    sr, sr_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [1:0]    tail_cnt, tail_cnt_nx;
  logic          trunc_nx;
  logic          out_valid_nx, out_last_nx;
  logic [1:0]    out_sym_nx;
  logic          free, accept, load, load_bit, last_sym;
  logic [3:0]    v;

  assign free        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = free && (state == IDLE || state == DATA);
  assign accept      = bus.in_valid && bus.in_ready;
  assign busy        = (state != IDLE) || bus.out_valid;

  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      state         <= IDLE;
      sr            <= 3'b000;
      bit_cnt       <= '0;
      tail_cnt      <= 2'd0;
      trunc         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sym   <= 2'b00;
      bus.out_last  <= 1'b0;
    end else begin
      state         <= state_nx;
      sr            <= sr_nx;
      bit_cnt       <= bit_cnt_nx;
      tail_cnt      <= tail_cnt_nx;
      trunc         <= trunc_nx;
      bus.out_valid <= out_valid_nx;
      bus.out_sym   <= out_sym_nx;
      bus.out_last  <= out_last_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    bit_cnt_nx   = bit_cnt;
    tail_cnt_nx  = tail_cnt;
    trunc_nx     = trunc;
    out_valid_nx = bus.out_valid;
    out_sym_nx   = bus.out_sym;
    out_last_nx  = bus.out_last;
    load         = 1'b0;
    load_bit     = 1'b0;
    last_sym     = 1'b0;

    case (state)
      IDLE: if (accept) begin
        load       = 1'b1;
        load_bit   = bus.in_bit;
        bit_cnt_nx = CW'(1);
        trunc_nx   = 1'b0;
        if (bus.in_last) begin
          state_nx = TAIL;
        end else if (MAX_FRAME == 1) begin
          trunc_nx = 1'b1;
          state_nx = TAIL;
        end else begin
          state_nx = DATA;
        end
      end
      DATA: if (accept) begin
        load       = 1'b1;
        load_bit   = bus.in_bit;
        bit_cnt_nx = bit_cnt + CW'(1);
        if (bus.in_last) begin
          state_nx = TAIL;
        end else if (bit_cnt_nx == CW'(MAX_FRAME)) begin
          // frame cut here; the source's next bit opens a new frame
          trunc_nx = 1'b1;
          state_nx = TAIL;
        end
      end
      TAIL: if (free) begin
        load        = 1'b1;
        tail_cnt_nx = tail_cnt + 2'd1;
        if (tail_cnt == 2'd2) begin
          last_sym = 1'b1;
          state_nx = FLUSH;
        end
      end
      FLUSH: if (bus.out_valid && bus.out_ready) begin
        sr_nx       = 3'b000;
        bit_cnt_nx  = '0;
        tail_cnt_nx = 2'd0;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    v = {load_bit, sr};
    if (load) begin
      sr_nx        = {load_bit, sr[2:1]};
      out_valid_nx = 1'b1;
      out_sym_nx   = {^(G0 & v), ^(G1 & v)};
      out_last_nx  = last_sym;
    end else if (bus.out_ready) begin
      out_valid_nx = 1'b0;
      out_last_nx  = 1'b0;
    end
  end
endmodule
